// File: rtl/dma_seq_pkg.sv
// dma_seq_pkg
// Shared definitions for the DMA command sequencer slice.
//   - default parameter constants for dma_cmd_sequencer
//   - state_e : sequencer FSM states
//   - cmd_t   : one load/store command as issued by the reservation
//               station (widths follow the default parameters)
// Optional feature macro used by this slice: DMA_SEQ_PERF_CNT_EN
package dma_seq_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_LEN_W   = 16;
  localparam int DEF_ROB_W   = 3;
  localparam int DEF_BURST   = 16;
  localparam int DEF_MAX_OUT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] start;
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_ROB_W-1:0]  robId;
    logic                  write;
  } cmd_t;

endpackage

// File: rtl/dma_cmd_sequencer_rr_arb2.sv
// rr_arb2
// Two-input round-robin arbiter used to pick between the ld and st
// command streams.
// Ports:
//   clock      : clock
//   reset      : synchronous, active-low
//   req_i[1:0] : requests (bit 0 = ld, bit 1 = st)
//   advance_i  : a grant was taken this cycle; move the pointer
//   gnt_o[1:0] : one-hot grant (or zero when nothing requests)
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // ptr_q names the requester that wins a tie: 0 = index 0, 1 = index 1.
  logic ptr_q;
  logic ptr_d;

  // A lone requester always wins; on a tie the pointer decides.
  always_comb begin
    gnt_o = req_i;
    if (req_i[0] && req_i[1]) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After any taken grant the pointer moves away from the winner, so the
  // other side has priority at the next tie.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (gnt_o != 2'b00)) begin
      ptr_d = gnt_o[0];
    end
  end

  // Pointer register; reset gives index 0 (ld) the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dma_cmd_sequencer.sv
// dma_cmd_sequencer
// Takes ld/st commands from the reservation station, splits each into
// DMA bursts of at most BURST words on one shared scratchpad port, keeps
// at most MAX_OUT bursts unacknowledged, and reports the command's robId
// once every burst has been acknowledged.
// Ports:
//   clock, reset        : clock, synchronous active-low reset
//   ld_* / st_*         : command offer (valid/ready, start, len, robId)
//   dma_req_*           : burst request (valid/ready, addr, len, write)
//   dma_resp_valid      : one pulse per acknowledged burst
//   completed_valid/bits: one-cycle completion pulse with robId
//   busy                : high whenever the sequencer is not idle
//   perf_busy_cycles, perf_bursts : only with DMA_SEQ_PERF_CNT_EN
// Optional feature macro: DMA_SEQ_PERF_CNT_EN
module dma_cmd_sequencer
  import dma_seq_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int ROB_W   = DEF_ROB_W,
  parameter int BURST   = DEF_BURST,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_start,
  input  logic [LEN_W-1:0]  ld_len,
  input  logic [ROB_W-1:0]  ld_robId,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_start,
  input  logic [LEN_W-1:0]  st_len,
  input  logic [ROB_W-1:0]  st_robId,
  output logic              dma_req_valid,
  input  logic              dma_req_ready,
  output logic [ADDR_W-1:0] dma_req_addr,
  output logic [7:0]        dma_req_len,
  output logic              dma_req_write,
  input  logic              dma_resp_valid,
  output logic              completed_valid,
  output logic [ROB_W-1:0]  completed_bits,
  output logic              busy
`ifdef DMA_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_bursts
`endif
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [ROB_W-1:0]  robId_q, robId_d;
  logic              write_q, write_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;

  logic [1:0]        gnt;
  logic              canAccept;
  logic              accept;
  logic [ADDR_W-1:0] selStart;
  logic [LEN_W-1:0]  selLen;
  logic [ROB_W-1:0]  selRobId;
  logic [LEN_W-1:0]  burstLen;
  logic              lastBurst;
  logic              reqFire;
  logic              respTake;

  rr_arb2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_i     ({st_valid, ld_valid}),
    .advance_i (accept),
    .gnt_o     (gnt)
  );

  // Commands are only taken while idle and out of reset; ready goes to
  // the arbitration winner alone, so at most one side fires per cycle.
  always_comb begin
    canAccept = (state_q == IDLE) && reset;
    ld_ready  = canAccept && gnt[0];
    st_ready  = canAccept && gnt[1];
    accept    = (ld_valid && ld_ready) || (st_valid && st_ready);
    selStart  = st_ready ? st_start : ld_start;
    selLen    = st_ready ? st_len   : ld_len;
    selRobId  = st_ready ? st_robId : ld_robId;
  end

  // Burst sizing and the DMA request side. The request can only drop by
  // reaching MAX_OUT, which needs a fire first, so a raised request stays
  // up with stable addr/len until it is taken.
  always_comb begin
    lastBurst     = (remaining_q <= LEN_W'(BURST));
    burstLen      = lastBurst ? remaining_q : LEN_W'(BURST);
    dma_req_valid = (state_q == ISSUE) && (outstanding_q < OUT_W'(MAX_OUT));
    reqFire       = dma_req_valid && dma_req_ready;
    respTake      = dma_resp_valid && (outstanding_q != '0);
    dma_req_addr  = addr_q;
    dma_req_len   = 8'(burstLen);
    dma_req_write = write_q;
  end

  // Outstanding-burst bookkeeping plus the IDLE/ISSUE/DRAIN/DONE walk.
  // A stray acknowledgement with nothing outstanding is dropped, and the
  // DRAIN exit looks at the post-update count so the final ack is counted
  // in the cycle it arrives.
  always_comb begin
    outstanding_d = outstanding_q + OUT_W'(reqFire) - OUT_W'(respTake);
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    robId_d       = robId_q;
    write_d       = write_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = selStart;
          remaining_d = selLen;
          robId_d     = selRobId;
          write_d     = st_ready;
          state_d     = (selLen == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (reqFire) begin
          addr_d      = addr_q + ADDR_W'(burstLen);
          remaining_d = remaining_q - burstLen;
          if (lastBurst) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any command in flight without reporting it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      robId_q       <= '0;
      write_q       <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      robId_q       <= robId_d;
      write_q       <= write_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Completion is a one-cycle pulse taken straight from the DONE state.
  always_comb begin
    completed_valid = (state_q == DONE);
    completed_bits  = completed_valid ? robId_q : '0;
    busy            = (state_q != IDLE);
  end

`ifdef DMA_SEQ_PERF_CNT_EN
  logic [31:0] perfBusy_q;
  logic [31:0] perfBursts_q;

  // Saturating activity counters: busy cycles and fired bursts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      perfBusy_q   <= '0;
      perfBursts_q <= '0;
    end else begin
      if (busy && (perfBusy_q != '1)) begin
        perfBusy_q <= perfBusy_q + 32'd1;
      end
      if (reqFire && (perfBursts_q != '1)) begin
        perfBursts_q <= perfBursts_q + 32'd1;
      end
    end
  end

  assign perf_busy_cycles = perfBusy_q;
  assign perf_bursts      = perfBursts_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// tb_dma_cmd_sequencer
// Scoreboard bench for dma_cmd_sequencer with default parameters
// (BURST=16, MAX_OUT=4). Expected bursts and completions are computed
// from each command when it is offered and compared as the DUT emits them.
// A responder acknowledges every burst three cycles after it fires and can
// be told to withhold acknowledgements.
module tb_dma_cmd_sequencer;
  import dma_seq_pkg::*;

  localparam int BURST = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0, st_valid = 1'b0;
  logic        ld_ready, st_ready;
  logic [15:0] ld_start = '0, st_start = '0;
  logic [15:0] ld_len = '0, st_len = '0;
  logic [2:0]  ld_robId = '0, st_robId = '0;
  logic        dma_req_valid;
  logic        dma_req_ready = 1'b1;
  logic [15:0] dma_req_addr;
  logic [7:0]  dma_req_len;
  logic        dma_req_write;
  logic        dma_resp_valid = 1'b0;
  logic        completed_valid;
  logic [2:0]  completed_bits;
  logic        busy;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic        write;
  } burst_t;

  typedef struct {
    logic [2:0] robId;
    bit         timed;
  } comp_t;

  burst_t expBursts[$];
  comp_t  expComps[$];
  int     respDue[$];

  int numTests = 0;
  int numFailed = 0;
  int cycle = 0;
  int lastRespCycle = -100;
  int reqFires = 0;
  bit holdResp = 1'b0;
  int releaseCount = 0;
  bit randReady = 1'b0;

  dma_cmd_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_start        (ld_start),
    .ld_len          (ld_len),
    .ld_robId        (ld_robId),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_start        (st_start),
    .st_len          (st_len),
    .st_robId        (st_robId),
    .dma_req_valid   (dma_req_valid),
    .dma_req_ready   (dma_req_ready),
    .dma_req_addr    (dma_req_addr),
    .dma_req_len     (dma_req_len),
    .dma_req_write   (dma_req_write),
    .dma_resp_valid  (dma_resp_valid),
    .completed_valid (completed_valid),
    .completed_bits  (completed_bits),
    .busy            (busy)
  );

  // Free-running clock and cycle counter.
  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cycle++;
  end

  // Hard stop in case a wait somewhere is not bounded as intended.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected summary before it");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    numTests++;
    if (actual !== expected) begin
      numFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Split a command into the bursts it should produce and queue them,
  // followed by its completion.
  task automatic pushCommand(input cmd_t c);
    logic [15:0] a;
    logic [15:0] r;
    logic [15:0] b;
    burst_t      e;
    comp_t       k;
    a = c.start;
    r = c.len;
    while (r != 16'd0) begin
      b = (r < 16'(BURST)) ? r : 16'(BURST);
      e.addr  = a;
      e.len   = b[7:0];
      e.write = c.write;
      expBursts.push_back(e);
      a = a + b;
      r = r - b;
    end
    k.robId = c.robId;
    k.timed = (c.len != 16'd0);
    expComps.push_back(k);
  endtask

  task automatic driveSide(input cmd_t c);
    if (c.write) begin
      st_valid = 1'b1; st_start = c.start; st_len = c.len; st_robId = c.robId;
    end else begin
      ld_valid = 1'b1; ld_start = c.start; ld_len = c.len; ld_robId = c.robId;
    end
  endtask

  // Offer a single command and hold it until the DUT takes it.
  task automatic applyStimulus(input cmd_t c);
    bit accepted;
    accepted = 1'b0;
    pushCommand(c);
    @(posedge clock); #1;
    driveSide(c);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (c.write ? st_ready : ld_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    ld_valid = 1'b0;
    st_valid = 1'b0;
    if (!accepted) checkOutput("acceptTimeout", 0, 1);
  endtask

  // Offer an ld and an st command in the same cycle; ld must win the tie.
  task automatic offerBoth(input cmd_t l, input cmd_t s);
    bit ldWon;
    bit accepted;
    pushCommand(l);
    pushCommand(s);
    @(posedge clock); #1;
    driveSide(l);
    driveSide(s);
    accepted = 1'b0;
    ldWon = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (ld_ready || st_ready) begin
        accepted = 1'b1;
        ldWon = ld_ready;
        break;
      end
    end
    checkOutput("tieWinnerLd", {31'd0, ldWon}, 1);
    @(posedge clock); #1;
    if (ldWon) ld_valid = 1'b0; else st_valid = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if ((ldWon && st_ready) || (!ldWon && ld_ready)) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    ld_valid = 1'b0;
    st_valid = 1'b0;
    if (!accepted) checkOutput("secondAcceptTimeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (expComps.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("idleTimeout", 0, 1);
  endtask

  // DMA responder: drives ready and returns one ack per fired burst three
  // cycles later, unless acknowledgements are being withheld.
  initial forever begin
    @(posedge clock); #2;
    dma_resp_valid = 1'b0;
    dma_req_ready  = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    if (respDue.size() > 0 && respDue[0] <= cycle &&
        (!holdResp || releaseCount > 0)) begin
      dma_resp_valid = 1'b1;
      void'(respDue.pop_front());
      lastRespCycle = cycle;
      if (holdResp) releaseCount--;
    end
  end

  // Monitor: request stability, burst scoreboard, completion scoreboard.
  initial begin
    bit          prevStall;
    logic [15:0] prevAddr;
    logic [7:0]  prevLen;
    burst_t      e;
    comp_t       k;
    prevStall = 1'b0;
    prevAddr = '0;
    prevLen = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("reqHoldValid", {31'd0, dma_req_valid}, 1);
          checkOutput("reqHoldAddr", {16'd0, dma_req_addr}, {16'd0, prevAddr});
          checkOutput("reqHoldLen", {24'd0, dma_req_len}, {24'd0, prevLen});
        end
        prevStall = dma_req_valid && !dma_req_ready;
        prevAddr  = dma_req_addr;
        prevLen   = dma_req_len;
        if (dma_req_valid && dma_req_ready) begin
          reqFires++;
          respDue.push_back(cycle + 3);
          if (expBursts.size() == 0) begin
            checkOutput("unexpectedReq", 1, 0);
          end else begin
            e = expBursts.pop_front();
            checkOutput("reqAddr", {16'd0, dma_req_addr}, {16'd0, e.addr});
            checkOutput("reqLen", {24'd0, dma_req_len}, {24'd0, e.len});
            checkOutput("reqWrite", {31'd0, dma_req_write}, {31'd0, e.write});
          end
        end
        if (completed_valid) begin
          if (expComps.size() == 0) begin
            checkOutput("unexpectedComplete", 1, 0);
          end else begin
            k = expComps.pop_front();
            checkOutput("completeRobId", {29'd0, completed_bits}, {29'd0, k.robId});
            if (k.timed) checkOutput("completeLatency", cycle, lastRespCycle + 1);
          end
        end
      end
    end
  end

  // Main sequence.
  initial begin
    int base;
    bit reached;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rstBusy", {31'd0, busy}, 0);
    checkOutput("rstReqValid", {31'd0, dma_req_valid}, 0);
    checkOutput("rstCompleted", {31'd0, completed_valid}, 0);
    checkOutput("rstReqAddr", {16'd0, dma_req_addr}, 0);
    checkOutput("rstReqLen", {24'd0, dma_req_len}, 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Tie from reset: ld (3 bursts, 0x100/0x110/0x120) then st.
    offerBoth('{start: 16'h0100, len: 16'd40, robId: 3'd1, write: 1'b0},
              '{start: 16'h0400, len: 16'd20, robId: 3'd2, write: 1'b1});
    waitIdle();

    // After an st was served the next tie goes back to ld.
    offerBoth('{start: 16'h3000, len: 16'd16, robId: 3'd3, write: 1'b0},
              '{start: 16'h5000, len: 16'd8,  robId: 3'd4, write: 1'b1});
    waitIdle();

    // Zero-length st: no DMA traffic, completion with robId 5.
    applyStimulus('{start: 16'h7000, len: 16'd0, robId: 3'd5, write: 1'b1});
    repeat (3) begin
      @(negedge clock);
      checkOutput("zeroLenNoReq", {31'd0, dma_req_valid}, 0);
    end
    waitIdle();

    // Address wrap, including a stalling DMA port.
    applyStimulus('{start: 16'hFFF8, len: 16'd16, robId: 3'd6, write: 1'b1});
    waitIdle();
    randReady = 1'b1;
    applyStimulus('{start: 16'hFFF8, len: 16'd40, robId: 3'd7, write: 1'b0});
    waitIdle();
    randReady = 1'b0;

    // Outstanding limit: 4 bursts then stop; one ack re-opens the port.
    holdResp = 1'b1;
    base = reqFires;
    applyStimulus('{start: 16'h0800, len: 16'd100, robId: 3'd0, write: 1'b0});
    repeat (12) @(negedge clock);
    checkOutput("maxOutFires", reqFires - base, 4);
    checkOutput("maxOutReqLow", {31'd0, dma_req_valid}, 0);
    @(posedge clock); #1;
    releaseCount = 1;
    @(negedge clock);
    checkOutput("releaseResp", {31'd0, dma_resp_valid}, 1);
    checkOutput("stillBlocked", {31'd0, dma_req_valid}, 0);
    @(negedge clock);
    checkOutput("fifthReqValid", {31'd0, dma_req_valid}, 1);
    holdResp = 1'b0;
    waitIdle();

    // Reset during DRAIN: silent drop, stray acks ignored afterwards.
    holdResp = 1'b1;
    base = reqFires;
    applyStimulus('{start: 16'h2000, len: 16'd40, robId: 3'd2, write: 1'b0});
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (reqFires - base == 3) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) checkOutput("drainReachTimeout", 0, 1);
    repeat (2) @(negedge clock);
    checkOutput("drainBusy", {31'd0, busy}, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    expComps.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("resetBusy", {31'd0, busy}, 0);
    checkOutput("resetNoComplete", {31'd0, completed_valid}, 0);
    holdResp = 1'b0;
    repeat (8) begin
      @(negedge clock);
      checkOutput("strayNoComplete", {31'd0, completed_valid}, 0);
    end
    checkOutput("strayIdle", {31'd0, busy}, 0);

    // Outstanding must be back at zero: a full window of 4 bursts issues.
    holdResp = 1'b1;
    base = reqFires;
    applyStimulus('{start: 16'h6000, len: 16'd80, robId: 3'd3, write: 1'b1});
    repeat (12) @(negedge clock);
    checkOutput("postResetFires", reqFires - base, 4);
    holdResp = 1'b0;
    waitIdle();
    checkOutput("burstsDrained", expBursts.size(), 0);

    $display("[TB] %0d tests run, %0d failed", numTests, numFailed);
    $finish;
  end

endmodule
